uart_mem_loader: RTL

- UART receiver that boots the data memory's contents from a host.
- Receives 8N1 bytes on `rx` and packs them big-endian into 32-bit words.
- Drives each word into the data memory's preload port (`en_addr_data` / `addr_data` / `data_data`).
- Sits directly upstream of the data memory; runs at the same baud rate as the memory's UART dump path, so the host uses one serial link for load and readback.

---
 rtl/uart_mem_loader.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mem_loader.sv
// ---------------------------------------------------------------------------
// uart_mem_loader
// Boots the data memory from a host over a UART link. 8N1 bytes received on
// rx are packed big-endian into 32-bit words and written through the data
// memory's preload port, one strobe per word, until WORDS words are loaded.
//
// Optional feature macro: LOADER_CSUM_EN
//   defined   : one extra byte after the last word must equal the XOR of all
//               data bytes; load_done or csum_err (sticky) reports the result.
//   undefined : no checksum byte, csum_err is constant 0.
//
// Ports
//   sys_clk       in   1   clock
//   sys_arstn     in   1   asynchronous active-low reset
//   rx            in   1   asynchronous UART line, idle high
//   en_addr_data  out  1   one-cycle preload write strobe
//   addr_data     out  5   byte address of the word ({word_idx, 2'b00})
//   data_data     out  32  word, first received byte in [31:24]
//   load_done     out  1   sticky, loading complete
//   frame_err     out  1   one-cycle pulse, stop bit sampled low
//   csum_err      out  1   sticky checksum mismatch
// ---------------------------------------------------------------------------
module uart_mem_loader #(
    parameter int unsigned UART_BPS = 115200,
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned WORDS    = 8
) (
    input  logic        sys_clk,
    input  logic        sys_arstn,
    input  logic        rx,
    output logic        en_addr_data,
    output logic [4:0]  addr_data,
    output logic [31:0] data_data,
    output logic        load_done,
    output logic        frame_err,
    output logic        csum_err
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned BAUD_HALF    = BAUD_CNT_MAX / 2;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned IDX_W        = 3;

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(BAUD_HALF);
    localparam logic [CNT_W-1:0] CNT_BIT   = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_n;

    // rx synchronizer plus one delayed copy for falling-edge detection
    logic rx_meta, rx_s, rx_s_d;

    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic [1:0]       byte_idx, byte_idx_n;
    logic [23:0]      word_buf, word_buf_n;
    logic [IDX_W-1:0] word_idx, word_idx_n;
    logic             fin_pend, fin_pend_n;
    logic             en_n, load_done_n, frame_err_n;
    logic [4:0]       addr_n;
    logic [31:0]      data_n;

`ifdef LOADER_CSUM_EN
    logic             csum_mode, csum_mode_n;
    logic [7:0]       csum_acc, csum_acc_n;
    logic             csum_err_n;
`endif

    // Two-stage synchronizer; resets to the idle level so no false start edge
    always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            word_idx     <= '0;
            fin_pend     <= 1'b0;
            en_addr_data <= 1'b0;
            addr_data    <= '0;
            data_data    <= '0;
            load_done    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_n;
            baud_cnt     <= baud_cnt_n;
            bit_cnt      <= bit_cnt_n;
            shift        <= shift_n;
            byte_idx     <= byte_idx_n;
            word_buf     <= word_buf_n;
            word_idx     <= word_idx_n;
            fin_pend     <= fin_pend_n;
            en_addr_data <= en_n;
            addr_data    <= addr_n;
            data_data    <= data_n;
            load_done    <= load_done_n;
            frame_err    <= frame_err_n;
        end
    end

`ifdef LOADER_CSUM_EN
    // Checksum tracking registers
    always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            csum_mode <= 1'b0;
            csum_acc  <= '0;
            csum_err  <= 1'b0;
        end else begin
            csum_mode <= csum_mode_n;
            csum_acc  <= csum_acc_n;
            csum_err  <= csum_err_n;
        end
    end
`else
    assign csum_err = 1'b0;
`endif

    // Next-state, receive datapath and output decode
    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        byte_idx_n  = byte_idx;
        word_buf_n  = word_buf;
        word_idx_n  = word_idx;
        fin_pend_n  = fin_pend;
        en_n        = 1'b0;
        addr_n      = addr_data;
        data_n      = data_data;
        load_done_n = load_done;
        frame_err_n = 1'b0;
`ifdef LOADER_CSUM_EN
        csum_mode_n = csum_mode;
        csum_acc_n  = csum_acc;
        csum_err_n  = csum_err;
`endif

        case (state)
            IDLE: begin
                if (rx_s_d && !rx_s) begin
                    state_n    = START;
                    baud_cnt_n = '0;
                end
            end

            START: begin
                // Mid start bit: a high line here was only a glitch
                if (baud_cnt == CNT_HALF) begin
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = rx_s ? IDLE : DATA;
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (baud_cnt == CNT_BIT) begin
                    baud_cnt_n = '0;
                    shift_n    = {rx_s, shift[7:1]};
                    bit_cnt_n  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (baud_cnt == CNT_BIT) begin
                    baud_cnt_n = '0;
                    state_n    = IDLE;
                    if (!rx_s) begin
                        frame_err_n = 1'b1;
`ifdef LOADER_CSUM_EN
                    end else if (csum_mode) begin
                        state_n = DONE;
                        if (shift == csum_acc) begin
                            load_done_n = 1'b1;
                        end else begin
                            csum_err_n = 1'b1;
                        end
`endif
                    end else begin
`ifdef LOADER_CSUM_EN
                        csum_acc_n = csum_acc ^ shift;
`endif
                        byte_idx_n = byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf_n[23:16] = shift;
                            2'd1: word_buf_n[15:8]  = shift;
                            2'd2: word_buf_n[7:0]   = shift;
                            default: begin
                                en_n   = 1'b1;
                                data_n = {word_buf, shift};
                                addr_n = {word_idx, 2'b00};
                                if (word_idx == LAST_WORD) begin
                                    word_idx_n = '0;
`ifdef LOADER_CSUM_EN
                                    csum_mode_n = 1'b1;
`else
                                    fin_pend_n  = 1'b1;
`endif
                                end else begin
                                    word_idx_n = word_idx + IDX_W'(1);
                                end
                            end
                        endcase
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end

            DONE: begin
                // Absorbing until reset; rx is ignored
            end

            default: state_n = IDLE;
        endcase

        // Final strobe is out this cycle; latch completion and stop listening
        if (fin_pend) begin
            fin_pend_n  = 1'b0;
            load_done_n = 1'b1;
            state_n     = DONE;
        end
    end

endmodule
